// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, digit index type and hex glyph table.
// All segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Element n of the packed array is the glyph for nibble n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, // F
    7'b0000110, // E
    7'b0100001, // d
    7'b1000110, // C
    7'b0000011, // b
    7'b0001000, // A
    7'b0010000, // 9
    7'b0000000, // 8
    7'b1111000, // 7
    7'b0000010, // 6
    7'b0010010, // 5
    7'b0011001, // 4
    7'b0110000, // 3
    7'b0100100, // 2
    7'b1111001, // 1
    7'b1000000  // 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder.
// Ports: nibble (4b hex digit in), seg (7b active-low {g,f,e,d,c,b,a} out).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_digit_driver.sv
// 4-digit 7-seg driver: double-buffered value, anti-ghost blanking.
// Ports: CLOCK, Reset (async low), Transistors (active-low digit select),
// Value/Load (buffered update), DotIn; outputs Anodes, Segments, Dot,
// Pending, all registered. Optional: LEADING_ZERO_BLANK_EN.
module seven_seg_digit_driver
  import seg7_pkg::*;
#(
  parameter int GhostCycles = 50,
  parameter int GhostBits   = 6
) (
  input  logic        CLOCK,
  input  logic        Reset,
  input  logic [3:0]  Transistors,
  input  logic [15:0] Value,
  input  logic        Load,
  input  logic [3:0]  DotIn,
  output logic [3:0]  Anodes,
  output logic [6:0]  Segments,
  output logic        Dot,
  output logic        Pending
);

  localparam logic [GhostBits-1:0] GHOST_LOAD =
    GhostBits'(GhostCycles);

  logic [3:0]           trans_q, trans_d;
  logic [GhostBits-1:0] ghost_q, ghost_d;
  logic [15:0]          disp_q, disp_d;
  logic [15:0]          buf_q, buf_d;
  logic                 pend_q, pend_d;
  logic [3:0]           anodes_q, anodes_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dot_q, dot_d;

  logic       sel_valid;
  digit_idx_t sel_idx;
  logic       changed;
  logic       frame_start;
  logic [3:0] nibble;
  logic [6:0] dec_seg;
  logic       lz_blank;

  always_comb begin
    sel_valid = 1'b1;
    sel_idx   = 2'd0;
    unique case (1'b1)
      (Transistors == 4'b1110): sel_idx = 2'd0;
      (Transistors == 4'b1101): sel_idx = 2'd1;
      (Transistors == 4'b1011): sel_idx = 2'd2;
      (Transistors == 4'b0111): sel_idx = 2'd3;
      default:                  sel_valid = 1'b0;
    endcase
  end

  assign changed     = (Transistors != trans_q);
  assign frame_start = changed && (Transistors == 4'b1110);

  always_comb begin
    trans_d = Transistors;
    ghost_d = ghost_q;
    if (changed) begin
      ghost_d = GHOST_LOAD;
    end else if (ghost_q != '0) begin
      ghost_d = ghost_q - GhostBits'(1);
    end
    disp_d = disp_q;
    buf_d  = buf_q;
    pend_d = pend_q;
    if (frame_start) begin
      // A Load landing on the frame edge bypasses the buffer.
      pend_d = 1'b0;
      if (Load) begin
        disp_d = Value;
      end else if (pend_q) begin
        disp_d = buf_q;
      end
    end else if (Load) begin
      buf_d  = Value;
      pend_d = 1'b1;
    end
  end

  // Decode from the next display value so a commit shows on digit 0.
  assign nibble = disp_d[{sel_idx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    unique case (sel_idx)
      2'd3:    lz_blank = (disp_d[15:12] == 4'h0);
      2'd2:    lz_blank = (disp_d[15:8] == 8'h00);
      2'd1:    lz_blank = (disp_d[15:4] == 12'h000);
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif
    seg_d = (!sel_valid || lz_blank) ? SEG_BLANK : dec_seg;
    dot_d = sel_valid ? ~DotIn[sel_idx] : 1'b1;
    // Using ghost_d gives exactly GhostCycles dark cycles.
    anodes_d = (!sel_valid || ghost_d != '0) ? ANODE_OFF
                                             : Transistors;
  end

  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      trans_q  <= 4'b1111;
      ghost_q  <= '0;
      disp_q   <= 16'h0000;
      buf_q    <= 16'h0000;
      pend_q   <= 1'b0;
      anodes_q <= ANODE_OFF;
      seg_q    <= SEG_BLANK;
      dot_q    <= 1'b1;
    end else begin
      trans_q  <= trans_d;
      ghost_q  <= ghost_d;
      disp_q   <= disp_d;
      buf_q    <= buf_d;
      pend_q   <= pend_d;
      anodes_q <= anodes_d;
      seg_q    <= seg_d;
      dot_q    <= dot_d;
    end
  end

  assign Anodes   = anodes_q;
  assign Segments = seg_q;
  assign Dot      = dot_q;
  assign Pending  = pend_q;

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Directed bench for seven_seg_digit_driver (GhostCycles=3).
// Vector table plus hand sequences for reset and hold corners.
module tb_seven_seg_digit_driver;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SD = 7'b0100001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] BK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BK;
`else
  localparam logic [6:0] LZ = S0;
`endif

  typedef struct {
    logic [3:0]  t;
    logic        ld;
    logic [15:0] v;
    logic [3:0]  di;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dot;
    logic        pend;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  trans = 4'b1110;
  logic [15:0] value = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  dot_in = 4'b0;
  logic [3:0]  anodes;
  logic [6:0]  segs;
  logic        dot;
  logic        pending;

  int checks = 0;
  int failures = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  seven_seg_digit_driver #(
    .GhostCycles (3),
    .GhostBits   (6)
  ) dut (
    .CLOCK       (clk),
    .Reset       (rst_n),
    .Transistors (trans),
    .Value       (value),
    .Load        (load),
    .DotIn       (dot_in),
    .Anodes      (anodes),
    .Segments    (segs),
    .Dot         (dot),
    .Pending     (pending)
  );

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] t, input logic ld,
                     input logic [15:0] v, input logic [3:0] di,
                     input logic [3:0] an, input logic [6:0] seg,
                     input logic d, input logic p);
    vec_t r;
    r.t = t; r.ld = ld; r.v = v; r.di = di;
    r.an = an; r.seg = seg; r.dot = d; r.pend = p;
    vq.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    add(4'b1110, 1, 16'h0000, 4'b0000, 4'b1111, S0, 1, 0);
    add(4'b1110, 0, 16'h0000, 4'b0000, 4'b1111, S0, 1, 0);
    add(4'b1110, 0, 16'h0000, 4'b0000, 4'b1111, S0, 1, 0);
    add(4'b1110, 0, 16'h0000, 4'b0000, 4'b1110, S0, 1, 0);
    add(4'b1101, 0, 16'h0000, 4'b0010, 4'b1111, S0, 0, 0);
    add(4'b1101, 0, 16'h0000, 4'b0010, 4'b1111, S0, 0, 0);
    add(4'b1101, 0, 16'h0000, 4'b0010, 4'b1111, S0, 0, 0);
    add(4'b1101, 0, 16'h0000, 4'b0010, 4'b1101, S0, 0, 0);
    add(4'b1101, 1, 16'h1A2F, 4'b0000, 4'b1101, S0, 1, 1);
    add(4'b1011, 0, 16'h0000, 4'b0000, 4'b1111, S0, 1, 1);
    add(4'b0111, 0, 16'h0000, 4'b0000, 4'b1111, S0, 1, 1);
    add(4'b1110, 0, 16'h0000, 4'b0000, 4'b1111, SF, 1, 0);
    add(4'b1110, 0, 16'h0000, 4'b0000, 4'b1111, SF, 1, 0);
    add(4'b1110, 0, 16'h0000, 4'b0000, 4'b1111, SF, 1, 0);
    add(4'b1110, 0, 16'h0000, 4'b0000, 4'b1110, SF, 1, 0);
    add(4'b1101, 0, 16'h0000, 4'b0000, 4'b1111, S2, 1, 0);
    add(4'b1011, 0, 16'h0000, 4'b0000, 4'b1111, SA, 1, 0);
    add(4'b0111, 0, 16'h0000, 4'b0000, 4'b1111, S1, 1, 0);
    add(4'b0111, 0, 16'h0000, 4'b0000, 4'b1111, S1, 1, 0);
    add(4'b0111, 0, 16'h0000, 4'b0000, 4'b1111, S1, 1, 0);
    add(4'b0111, 0, 16'h0000, 4'b0000, 4'b0111, S1, 1, 0);
    add(4'b0111, 1, 16'h1234, 4'b0000, 4'b0111, S1, 1, 1);
    add(4'b0111, 1, 16'h5678, 4'b0000, 4'b0111, S1, 1, 1);
    add(4'b1110, 0, 16'h0000, 4'b0000, 4'b1111, S8, 1, 0);
    add(4'b1101, 0, 16'h0000, 4'b0000, 4'b1111, S7, 1, 0);
    add(4'b1011, 0, 16'h0000, 4'b0000, 4'b1111, S6, 1, 0);
    add(4'b0111, 0, 16'h0000, 4'b0000, 4'b1111, S5, 1, 0);
    add(4'b1110, 1, 16'hC0DE, 4'b0000, 4'b1111, SE, 1, 0);
    add(4'b1101, 0, 16'h0000, 4'b0000, 4'b1111, SD, 1, 0);
    add(4'b1100, 0, 16'h0000, 4'b1111, 4'b1111, BK, 1, 0);
    add(4'b1111, 0, 16'h0000, 4'b1111, 4'b1111, BK, 1, 0);
    add(4'b1111, 1, 16'h00A0, 4'b1000, 4'b1111, BK, 1, 1);
    add(4'b1110, 0, 16'h0000, 4'b1000, 4'b1111, S0, 1, 0);
    add(4'b1101, 0, 16'h0000, 4'b1000, 4'b1111, SA, 1, 0);
    add(4'b1011, 0, 16'h0000, 4'b1000, 4'b1111, LZ, 1, 0);
    add(4'b0111, 0, 16'h0000, 4'b1000, 4'b1111, LZ, 0, 0);
    add(4'b0111, 0, 16'h0000, 4'b1000, 4'b1111, LZ, 0, 0);
    add(4'b0111, 0, 16'h0000, 4'b1000, 4'b1111, LZ, 0, 0);
    add(4'b0111, 0, 16'h0000, 4'b1000, 4'b0111, LZ, 0, 0);

    tick();
    tick();
    chk("rst_anodes", 0, 16'(anodes), 16'hF);
    chk("rst_segs", 0, 16'(segs), 16'(BK));
    chk("rst_dot", 0, 16'(dot), 16'h1);
    chk("rst_pend", 0, 16'(pending), 16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      trans  = vq[i].t;
      load   = vq[i].ld;
      value  = vq[i].v;
      dot_in = vq[i].di;
      tick();
      chk("anodes", i + 1, 16'(anodes), 16'(vq[i].an));
      chk("segs", i + 1, 16'(segs), 16'(vq[i].seg));
      chk("dot", i + 1, 16'(dot), 16'(vq[i].dot));
      chk("pend", i + 1, 16'(pending), 16'(vq[i].pend));
    end

    // Reset while blanking with a value pending.
    trans = 4'b1011; load = 1'b1; value = 16'h9999; dot_in = 4'b0100;
    tick();
    load = 1'b0;
    chk("pre_rst_pend", 100, 16'(pending), 16'h1);
    chk("pre_rst_an", 100, 16'(anodes), 16'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", 101, 16'(anodes), 16'hF);
    chk("async_rst_seg", 101, 16'(segs), 16'(BK));
    chk("async_rst_dot", 101, 16'(dot), 16'h1);
    chk("async_rst_pend", 101, 16'(pending), 16'h0);
    tick();
    rst_n = 1'b1;
    trans = 4'b1110; dot_in = 4'b0000;
    tick();
    chk("post_rst_seg", 102, 16'(segs), 16'(S0));
    chk("post_rst_pend", 102, 16'(pending), 16'h0);
    chk("post_rst_an", 102, 16'(anodes), 16'hF);
    repeat (3) tick();
    chk("post_rst_an_on", 103, 16'(anodes), 16'hE);
    chk("post_rst_seg2", 103, 16'(segs), 16'(S0));

    // Constant select: no frame edge, pending holds indefinitely.
    load = 1'b1; value = 16'h4321;
    tick();
    load = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("hold_pend", 200 + k, 16'(pending), 16'h1);
      chk("hold_seg", 200 + k, 16'(segs), 16'(S0));
    end
    chk("hold_an", 230, 16'(anodes), 16'hE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_digit_driver.md
Name: seven_seg_digit_driver

Overview:
Downstream consumer of the 4-digit refresh scanner's active-low digit-select vector (Transistors).
- Holds a 16-bit hex display value, double-buffered so updates never tear mid-frame.
- Decodes the selected nibble to active-low segments and drives the anodes with an anti-ghosting blank window.
- Outputs go straight to the board's 7-segment pins.

Parameters:
GhostCycles, 50, clock cycles anodes are held off after each digit change (0 = no blanking)
GhostBits, 6, width of ghost counter; must satisfy 2^GhostBits > GhostCycles

Ports:
CLOCK  input  1  system clock
Reset  input  1  asynchronous, active-low reset
Transistors  input  4  active-low one-hot digit select from scanner; bit i low selects digit i
Value  input  16  hex value; digit i = Value[4i+3:4i]
Load  input  1  single-cycle strobe; capture Value into pending buffer
DotIn  input  4  decimal point request per digit, active-high
Anodes  output  4  active-low anode drive to board
Segments  output  7  active-low {g,f,e,d,c,b,a}
Dot  output  1  active-low decimal point
Pending  output  1  high while a loaded value awaits frame-boundary commit

Behaviour:
- Reset (async, Reset=0):
  - Anodes=4'b1111, Segments=7'b1111111, Dot=1, Pending=0.
  - Display register=16'h0000, pending buffer=0, previous-Transistors register=4'b1111, ghost counter=0.
- All state updates on posedge CLOCK. All outputs are registered.
- Digit selection:
  - Exactly one bit of Transistors low selects that digit.
  - Any other pattern (1111, two or more zeros) is illegal: next cycle Anodes=1111, Segments=1111111, Dot=1.
- Latency: Segments, Dot and Anodes reflect a Transistors change one cycle later.
- Hex decode (active-low), all 16 codes:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000
  - 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011
  - C:1000110, d:0100001, E:0000110, F:0001110
- Dot = ~DotIn[selected digit].
- Ghost blanking:
  - When Transistors differs from its previous registered value, load ghost counter with GhostCycles.
  - While counter ≠ 0: decrement each cycle and force Anodes=1111. Segments still update so they are settled when anodes enable.
  - When counter = 0: Anodes = registered Transistors.
  - GhostCycles=0 disables blanking.
- Double buffering:
  - Load=1 copies Value into the pending buffer and sets Pending=1.
  - A second Load while Pending=1 overwrites the buffer; last value wins.
  - Commit occurs in the cycle Transistors changes to 4'b1110 (start of frame): display register takes the pending buffer, Pending clears.
  - Load and commit in the same cycle: the display register takes the incoming Value directly and Pending=0.
  - Commit with Pending=0 leaves the display register unchanged.
- Transistors held constant indefinitely: no commit occurs; Pending stays high.
- Reset asserted mid-blank or mid-pending: all state returns to reset values immediately; the pending value is lost.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: digit i (i = 3..1) is blanked (Segments=1111111; Dot still driven) when its nibble and all higher nibbles of the display register are 0. Digit 0 is never blanked, so 16'h0000 shows "0" and 16'h00A0 shows "A0".
- Undefined: all four digits always display, including leading zeros.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_BLANK=7'b1111111 and ANODE_OFF=4'b1111
  - hex-to-segment constant table
  - digit index type (2 bits)
- One natural sub-module: hex_to_seg7, the combinational nibble-to-segment decoder, reusable by other display blocks.
- Counter, buffering and output registers stay in the top module.

Test Plan:
1. Reset low with Transistors=1110 → Anodes=1111, Segments=1111111, Dot=1, Pending=0. Release, Value loaded 16'h0000 → digit 0 shows 1000000 after ghost window.
2. GhostCycles=3, Transistors 1110→1101 → Anodes=1111 for 3 cycles, then 1101. Segments show digit 1's code from the cycle after the change.
3. Load Value=16'h1A2F with Transistors sequence 1101,1011,0111 → Pending=1 and display unchanged. On the change to 1110 → Pending=0. Scan then shows F, 2, A, 1 (0001110, 0100100, 0001000, 1111001).
4. Load 16'h1234 then Load 16'h5678 before the frame boundary → only 5678 is ever displayed. Load coincident with the 0111→1110 change → new Value displayed that frame, Pending=0.
5. Transistors=1100, then 1111 → Anodes=1111 and Segments=1111111 in both cases.
6. LEADING_ZERO_BLANK_EN defined, display 16'h00A0 → digits 3 and 2 blank, digit 1 shows 0001000, digit 0 shows 1000000. Undefined → digits 3 and 2 show 1000000.
